branch_predictor: RTL and testbench

// - Fetch-stage dynamic branch predictor: BHT of 2-bit saturating counters plus tagged BTB.
// - Predicts direction and target for PCF; carries the prediction down F->D->E in lockstep with the pipeline.
// - Presents BranchPredictedE to the hazard/branch unit, which flushes D when PCSrcE != BranchPredictedE.
// - Trains from the resolved outcome of conditional branches in E.

---
 rtl/branch_predictor.sv | 166 ++++++++++++++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage BHT + tagged BTB branch predictor with F->D->E prediction pipeline
// Optional build macro: BP_GSHARE_EN (global-history hashed counter index)
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   PCF                         fetch PC used for the combinational lookup
//   PredTakenF, PredTargetF     predicted direction and target for PCF
//   StallD, FlushD, FlushE      pipeline control for the D and E prediction registers
//   BranchE, PCE, PCTargetE,    resolved conditional branch in E (trains the tables)
//   PCSrcE
//   BranchPredictedE            prediction travelling with the E-stage instruction
//   MispredictE                 resolved branch disagrees with its prediction
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            BranchE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PCSrcE,
  output logic            BranchPredictedE,
  output logic            MispredictE
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = XLEN - IDX_BITS - 2;

  // BTB and BHT storage
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  // Prediction carried alongside the instruction
  logic pred_dec_q, pred_dec_d;
  logic pred_exe_q, pred_exe_d;

  logic [IDX_BITS-1:0] i_f, i_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  logic [IDX_BITS-1:0] cidx_f, cidx_e;
  logic                hit_f, hit_e;

  // Byte-offset bits never select anything
  logic unused_pc;
  assign unused_pc = ^{PCF[1:0], PCE[1:0]};

  assign i_f   = PCF[IDX_BITS+1:2];
  assign tag_f = PCF[XLEN-1:IDX_BITS+2];
  assign i_e   = PCE[IDX_BITS+1:2];
  assign tag_e = PCE[XLEN-1:IDX_BITS+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [IDX_BITS-1:0] ghr_pad;
  logic [IDX_BITS-1:0] idx_dec_q, idx_dec_d;
  logic [IDX_BITS-1:0] idx_exe_q, idx_exe_d;

  always_comb begin
    ghr_pad                = '0;
    ghr_pad[GHR_BITS-1:0]  = ghr_q;
  end

  // Counter index is hashed with resolved history; the hashed index rides
  // with the instruction so training hits the same counter that predicted.
  assign cidx_f = i_f ^ ghr_pad;
  assign cidx_e = idx_exe_q;

  always_comb begin
    ghr_d     = BranchE ? {ghr_q[GHR_BITS-2:0], PCSrcE} : ghr_q;
    idx_dec_d = FlushD ? '0 : (StallD ? idx_dec_q : cidx_f);
    idx_exe_d = FlushE ? '0 : idx_dec_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q     <= '0;
      idx_dec_q <= '0;
      idx_exe_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      idx_dec_q <= idx_dec_d;
      idx_exe_q <= idx_exe_d;
    end
  end
`else
  // History length only matters for the gshare build
  logic [GHR_BITS-1:0] unused_ghr;
  assign unused_ghr = '0;

  assign cidx_f = i_f;
  assign cidx_e = i_e;
`endif

  // Lookup: asynchronous read of pre-update contents
  assign hit_f       = valid_q[i_f] && (tag_q[i_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[cidx_f][1];
  assign PredTargetF = hit_f ? target_q[i_f] : '0;

  assign hit_e = valid_q[i_e] && (tag_q[i_e] == tag_e);

  // Training
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (BranchE) begin
      if (hit_e) begin
        if (PCSrcE) begin
          if (ctr_q[cidx_e] != 2'b11) ctr_d[cidx_e] = ctr_q[cidx_e] + 2'b01;
          target_d[i_e] = PCTargetE;
        end else begin
          if (ctr_q[cidx_e] != 2'b00) ctr_d[cidx_e] = ctr_q[cidx_e] - 2'b01;
        end
      end else begin
        // Allocate or replace; new entries start weak in the observed direction
        valid_d[i_e]  = 1'b1;
        tag_d[i_e]    = tag_e;
        target_d[i_e] = PCTargetE;
        ctr_d[cidx_e] = PCSrcE ? 2'b10 : 2'b01;
      end
    end
  end

  // Pipeline registers: flush has priority over stall
  always_comb begin
    pred_dec_d = FlushD ? 1'b0 : (StallD ? pred_dec_q : PredTakenF);
    pred_exe_d = FlushE ? 1'b0 : pred_dec_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      pred_dec_q <= 1'b0;
      pred_exe_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      pred_dec_q <= pred_dec_d;
      pred_exe_q <= pred_exe_d;
    end
  end

  assign BranchPredictedE = pred_exe_q;
  assign MispredictE      = BranchE && (PCSrcE != pred_exe_q);

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        StallD, FlushD, FlushE;
  logic        BranchE;
  logic [31:0] PCE, PCTargetE;
  logic        PCSrcE;
  logic        BranchPredictedE;
  logic        MispredictE;

  branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .PCF             (PCF),
    .PredTakenF      (PredTakenF),
    .PredTargetF     (PredTargetF),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .BranchE         (BranchE),
    .PCE             (PCE),
    .PCTargetE       (PCTargetE),
    .PCSrcE          (PCSrcE),
    .BranchPredictedE(BranchPredictedE),
    .MispredictE     (MispredictE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic        br;
    logic [31:0] pce;
    logic [31:0] tgt;
    logic        src;
    logic        stall;
    logic        fd;
    logic        fe;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_bpe;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic [31:0] pcf, logic br, logic [31:0] pce, logic [31:0] tgt,
                              logic src, logic stall, logic fd, logic fe,
                              logic et, logic [31:0] etg, logic eb);
    vec_t v;
    v.pcf = pcf; v.br = br; v.pce = pce; v.tgt = tgt; v.src = src;
    v.stall = stall; v.fd = fd; v.fe = fe;
    v.exp_taken = et; v.exp_target = etg; v.exp_bpe = eb;
    return v;
  endfunction

  task automatic check1(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    PCF = v.pcf; BranchE = v.br; PCE = v.pce; PCTargetE = v.tgt; PCSrcE = v.src;
    StallD = v.stall; FlushD = v.fd; FlushE = v.fe;
  endtask

  task automatic check_front(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard step %0d: got=empty want=entry", idx);
    end else begin
      e = sb.pop_front();
      check1("PredTakenF", idx, 32'(PredTakenF), 32'(e.exp_taken));
      check1("PredTargetF", idx, PredTargetF, e.exp_target);
      check1("BranchPredictedE", idx, 32'(BranchPredictedE), 32'(e.exp_bpe));
      check1("MispredictE", idx, 32'(MispredictE), 32'(e.br & (e.src != e.exp_bpe)));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    check_front(idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Main table: mk(pcf, br, pce, tgt, src, stall, fd, fe, exp_taken, exp_target, exp_bpe)
    tbl.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(32'h104, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(32'h3FC, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h140, 1, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 0, 0, 1, 32'h140, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h140, 1, 0, 0, 0, 1, 32'h140, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h140, 0, 0, 0, 0, 1, 32'h140, 1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h140, 0, 0, 0, 0, 1, 32'h140, 1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h140, 0, 0, 0, 0, 0, 32'h140, 1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h140, 0, 0, 0, 0, 0, 32'h140, 1));
    tbl.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h140, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h180, 1, 0, 0, 0, 0, 32'h140, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 32'h180, 1, 0, 0, 0, 0, 32'h180, 0));
    tbl.push_back(mk(32'h200, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 0, 0, 1, 32'h180, 0));
    tbl.push_back(mk(32'h104, 1, 32'h200, 32'h240, 0, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(32'h200, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h240, 0));
    tbl.push_back(mk(32'h104, 0, 32'h3FC, 32'h500, 1, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(32'h3FC, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   0));

    // Reset state
    reset = 1'b1;
    drive(mk(32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0));
    sb.push_back(mk(32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0));
    @(negedge clk);
    check_front(-1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // Stall holds D, FlushE clears E, FlushD beats StallD
    apply(mk(32'h104, 1, 32'h108, 32'h1C0, 1, 0, 0, 0, 0, 32'h0,   0), 100);
    apply(mk(32'h108, 0, 32'h0,   32'h0,   0, 0, 0, 0, 1, 32'h1C0, 0), 101);
    apply(mk(32'h104, 0, 32'h0,   32'h0,   0, 1, 0, 0, 0, 32'h0,   0), 102);
    apply(mk(32'h104, 0, 32'h0,   32'h0,   0, 1, 0, 0, 0, 32'h0,   1), 103);
    apply(mk(32'h104, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   1), 104);
    apply(mk(32'h108, 0, 32'h0,   32'h0,   0, 0, 0, 1, 1, 32'h1C0, 1), 105);
    apply(mk(32'h104, 0, 32'h0,   32'h0,   0, 0, 0, 1, 0, 32'h0,   0), 106);
    apply(mk(32'h108, 0, 32'h0,   32'h0,   0, 0, 0, 0, 1, 32'h1C0, 0), 107);
    apply(mk(32'h104, 0, 32'h0,   32'h0,   0, 1, 1, 0, 0, 32'h0,   0), 108);
    apply(mk(32'h104, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   1), 109);
    apply(mk(32'h104, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 32'h0,   0), 110);

    // Same-cycle lookup and update at 0x100: no bypass
    apply(mk(32'h104, 1, 32'h100, 32'h150, 0, 0, 0, 0, 0, 32'h0,   0), 200);
    apply(mk(32'h100, 1, 32'h100, 32'h150, 1, 0, 0, 0, 0, 32'h150, 0), 201);
    apply(mk(32'h100, 0, 32'h0,   32'h0,   0, 0, 0, 0, 1, 32'h150, 0), 202);

    // Asynchronous reset mid-cycle, with an update pending
    drive(mk(32'h100, 1, 32'h108, 32'h1C0, 1, 0, 0, 0, 0, 32'h0, 0));
    sb.push_back(mk(32'h100, 1, 32'h108, 32'h1C0, 1, 0, 0, 0, 0, 32'h0, 0));
    #2;
    reset = 1'b1;
    @(negedge clk);
    check_front(300);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk(32'h108, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0), 301);
    apply(mk(32'h100, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0), 302);
    apply(mk(32'h200, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0), 303);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
